// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes, FSM state type and op-class helper for alu_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SLL = 4'b0011;
    localparam logic [3:0] c_OP_SRL = 4'b0100;
    localparam logic [3:0] c_OP_SRA = 4'b0101;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;
    localparam logic [3:0] c_OP_MUL = 4'b1000;
    localparam logic [3:0] c_OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_SINGLE  = 2'd0,
        CLS_SHIFT   = 2'd1,
        CLS_MUL     = 2'd2,
        CLS_ILLEGAL = 2'd3
    } op_class_t;

    function automatic op_class_t op_class(input logic [3:0] op);
        case (op)
            c_OP_AND, c_OP_OR, c_OP_ADD,
            c_OP_SUB, c_OP_SLT, c_OP_NOR: op_class = CLS_SINGLE;
            c_OP_SLL, c_OP_SRL, c_OP_SRA: op_class = CLS_SHIFT;
            c_OP_MUL:                     op_class = CLS_MUL;
            default:                      op_class = CLS_ILLEGAL;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core_comb.sv
// ============================================================================
// Module      : alu_core_comb
// Description : Single-cycle ALU datapath: logic ops, add/sub, SLT and flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    logic           w_add_ovf;
    logic           w_sub_ovf;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    // Subtract as a + ~b + 1 so the top bit is the no-borrow carry.
    assign w_diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1]  != a[WIDTH-1]);
    assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            c_OP_AND: result = a & b;
            c_OP_OR:  result = a | b;
            c_OP_NOR: result = ~(a | b);
            c_OP_ADD: begin
                result   = w_sum[WIDTH-1:0];
                carry    = w_sum[WIDTH];
                overflow = w_add_ovf;
            end
            c_OP_SUB: begin
                result   = w_diff[WIDTH-1:0];
                carry    = w_diff[WIDTH];
                overflow = w_sub_ovf;
            end
            // Sign of the difference corrected by overflow gives the true signed compare.
            c_OP_SLT: result = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] ^ w_sub_ovf};
            default:  result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module      : alu_seq
// Description : Handshaked ALU with iterative shifter and shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             out_carry,
    output logic             out_illegal
);

    localparam int CW = SHW + 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_op;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;

    op_class_t        w_in_class;
    logic [SHW-1:0]   w_in_amt;
    logic [CW-1:0]    w_start_count;
    logic [WIDTH-1:0] w_start_result;
    logic [WIDTH-1:0] w_core_result;
    logic             w_core_carry;
    logic             w_core_ovf;
    logic [WIDTH-1:0] w_step;
    logic             w_last;

    alu_core_comb #(.WIDTH(WIDTH)) u_core (
        .a        (in_a),
        .b        (in_b),
        .op       (in_op),
        .result   (w_core_result),
        .carry    (w_core_carry),
        .overflow (w_core_ovf)
    );

    assign w_in_class = op_class(in_op);
    assign w_in_amt   = in_b[SHW-1:0];
    assign w_last     = (r_count == CW'(1));

    // A nonzero start count is exactly the set of ops that need BUSY cycles.
    assign w_start_count  = (w_in_class == CLS_MUL)   ? CW'(WIDTH) :
                            (w_in_class == CLS_SHIFT) ? CW'(w_in_amt) : '0;
    assign w_start_result = (w_in_class == CLS_SHIFT) ? in_a : w_core_result;

    always_comb begin
        w_step = r_acc;
        case (r_op)
            c_OP_SLL: w_step = r_acc << 1;
            c_OP_SRL: w_step = r_acc >> 1;
            c_OP_SRA: w_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
            c_OP_MUL: w_step = r_acc + (r_mplier[0] ? r_mcand : '0);
            default:  w_step = r_acc;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (in_valid) w_state_next = (w_start_count != '0) ? BUSY : DONE;
            BUSY: if (w_last) w_state_next = DONE;
            DONE: if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            r_op         <= '0;
            r_count      <= '0;
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            out_result   <= '0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_carry    <= 1'b0;
            out_illegal  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            in_ready  <= (w_state_next == IDLE);
            out_valid <= (w_state_next == DONE);
            case (r_state)
                IDLE: if (in_valid) begin
                    r_op         <= in_op;
                    r_mcand      <= in_a;
                    r_mplier     <= in_b;
                    r_acc        <= (w_in_class == CLS_MUL) ? '0 : in_a;
                    r_count      <= w_start_count;
                    out_result   <= w_start_result;
                    out_zero     <= (w_start_result == '0);
                    out_carry    <= w_core_carry;
                    out_overflow <= w_core_ovf;
                    out_illegal  <= (w_in_class == CLS_ILLEGAL);
                end
                BUSY: begin
                    r_acc    <= w_step;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count - CW'(1);
                    if (w_last) begin
                        out_result <= w_step;
                        out_zero   <= (w_step == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width; legal values are powers of two, 8 to 64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width, derived from WIDTH and not overridden.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operation request.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-007 SHALL have ports in_a and in_b, inputs, WIDTH bits each: signed operands.
REQ-008 SHALL have port in_op, input, 4 bits: opcode.
REQ-009 SHALL have port out_valid, output, 1 bit: result available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port out_result, output, WIDTH bits: result.
REQ-012 SHALL have ports out_zero, out_overflow, out_carry and out_illegal, outputs, 1 bit each: status flags.

Function
REQ-013 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 0011 SLL, 0100 SRL, 0101 SRA, 1000 MUL (low WIDTH bits of product). Every other code is illegal.
REQ-014 FSM states SHALL be IDLE, BUSY and DONE. in_ready = 1 only in IDLE. out_valid = 1 only in DONE.
REQ-015 Accept SHALL occur when in_valid && in_ready at a rising edge. Accept latches in_a, in_b and in_op.
REQ-016 On accept, SHALL go to DONE on the next edge for: single-cycle ops (AND, OR, ADD, SUB, SLT, NOR), illegal ops, and shifts with in_b[SHW-1:0] == 0. Latency is 1 cycle.
REQ-017 On accept of a shift with a nonzero amount, SHALL go to BUSY with count = in_b[SHW-1:0]. Each BUSY cycle shifts 1 bit and decrements count; the FSM goes to DONE on the edge where count goes 1 to 0. Latency is 1+amount.
REQ-018 SRA SHALL replicate the sign bit. SRL and SLL SHALL fill with zeros. in_b bits above SHW-1 SHALL be ignored.
REQ-019 MUL SHALL be shift-add, one multiplier bit per BUSY cycle, for WIDTH iterations. Latency is 1+WIDTH. The result SHALL equal (in_a*in_b) mod 2^WIDTH.
REQ-020 ADD and SUB SHALL wrap modulo 2^WIDTH.
REQ-021 out_carry SHALL be the carry-out of the MSB for ADD and SUB; for SUB it is 1 when there is no borrow. It SHALL be 0 for all other ops.
REQ-022 out_overflow SHALL be signed overflow for ADD and SUB only, otherwise 0.
REQ-023 SLT SHALL return 1 or 0 per a true signed compare. The compare SHALL be correct even when A-B overflows.
REQ-024 out_zero SHALL be 1 exactly when out_result == 0, for every op.
REQ-025 An illegal op SHALL produce out_result=0, out_zero=1, out_illegal=1 and all other flags 0. out_illegal SHALL be 0 for legal ops.
REQ-026 In DONE, the result and flags SHALL be held stable until out_ready. On out_valid && out_ready, go to IDLE. No new accept is possible in that same cycle.
REQ-027 in_valid SHALL be ignored outside IDLE. Changes to in_a, in_b or in_op during BUSY or DONE SHALL not affect the result.

Reset
REQ-028 While reset=1 at an edge, state SHALL go to IDLE with in_ready=1, out_valid=0, out_result=0, all flags 0 and count=0.
REQ-029 Reset asserted in BUSY or DONE SHALL abort the operation and discard its result. No out_valid SHALL follow.
REQ-030 Reset SHALL take priority over accept and handshake in the same cycle.

Structure
REQ-031 Package alu_pkg SHALL hold: the opcode localparams, the state enum {IDLE, BUSY, DONE}, and the op-class helper function (single-cycle, shift, mul, illegal).
REQ-032 Single-cycle logic (logic ops, add/sub, SLT, flags) SHALL be one combinational sub-module, alu_core_comb, parametrised by WIDTH. The FSM, shifter iteration and multiplier SHALL live in alu_seq.
REQ-033 All outputs SHALL be registered.

Verification
REQ-034 WIDTH=64, ADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> out_valid 1 cycle after accept; result 0x8000_0000_0000_0000; overflow=1, carry=0, zero=0.
REQ-035 SUB 5-5 -> result 0, zero=1, carry=1, overflow=0. SLT A=0x8000_0000_0000_0000, B=1 -> result 1, despite overflow of A-B.
REQ-036 SRA A=0xF000_0000_0000_0000, B=4 -> out_valid 5 cycles after accept; result 0xFF00_0000_0000_0000. SLL with B=64 (amount 0) -> latency 1, result=A.
REQ-037 MUL 0xFFFF_FFFF_FFFF_FFFF * 3 -> out_valid 65 cycles after accept; result 0xFFFF_FFFF_FFFF_FFFD. Toggling in_a and in_valid during BUSY has no effect.
REQ-038 out_ready held 0 for 10 cycles in DONE -> result and flags stable, in_ready=0. Illegal op 1111 -> illegal=1, zero=1, result 0.
REQ-039 Reset pulsed mid-MUL (cycle 20) -> next cycle IDLE, in_ready=1, no out_valid. WIDTH=8 rerun of REQ-034..037 scaled: 0x7F+1 -> 0x80 with overflow=1; MUL latency 9.
